control_unit: RTL and testbench

CONTROL_UNIT -- requirements
Module: control_unit

---
 rtl/control_unit.sv | 282 ++++++++++++++++++++++++++++
 tb/tb_control_unit.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/control_unit.sv
// Multi-cycle MIPS-subset control unit: a single state register plus
// combinational decode of state, opcode and the ALU zero/sign flags.
module control_unit (
  input  logic       CLK,
  input  logic       RST,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       sign,
  output logic       PCWre,
  output logic [1:0] PCSrc,
  output logic       IRWre,
  output logic       RegWre,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       DBDataSrc,
  output logic       WrRegDSrc,
  output logic       ExtSel,
  output logic [1:0] RegDst,
  output logic [2:0] ALUOp,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IF    = 3'b000,
    S_ID    = 3'b001,
    S_EXE_L = 3'b010,
    S_MEM   = 3'b011,
    S_WB_L  = 3'b100,
    S_EXE_B = 3'b101,
    S_EXE_A = 3'b110,
    S_WB_A  = 3'b111
  } state_e;

  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_ADDI = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b010000;
  localparam logic [5:0] OP_AND  = 6'b010001;
  localparam logic [5:0] OP_ORI  = 6'b010010;
  localparam logic [5:0] OP_SLL  = 6'b011000;
  localparam logic [5:0] OP_SLT  = 6'b100110;
  localparam logic [5:0] OP_SLTI = 6'b100111;
  localparam logic [5:0] OP_SW   = 6'b110000;
  localparam logic [5:0] OP_LW   = 6'b110001;
  localparam logic [5:0] OP_BEQ  = 6'b110100;
  localparam logic [5:0] OP_BNE  = 6'b110101;
  localparam logic [5:0] OP_BLTZ = 6'b110110;
  localparam logic [5:0] OP_J    = 6'b111000;
  localparam logic [5:0] OP_JR   = 6'b111001;
  localparam logic [5:0] OP_JAL  = 6'b111010;
  localparam logic [5:0] OP_HALT = 6'b111111;

  state_e state_q;
  state_e state_d;

  logic       is_arith_s;
  logic       is_branch_s;
  logic       is_mem_s;
  logic       is_jump_s;
  logic       is_halt_s;
  logic       br_taken_s;
  logic [1:0] jump_src_s;
  logic [1:0] reg_dst_s;
  logic [2:0] alu_op_s;
  logic       alu_src_a_s;
  logic       alu_src_b_s;
  logic       db_data_src_s;
  logic       wr_reg_d_src_s;
  logic       ext_sel_s;

  logic       pc_wre_s;
  logic [1:0] pc_src_s;
  logic       ir_wre_s;
  logic       reg_wre_s;
  logic       mrd_s;
  logic       mwr_s;

  // Opcode decode: instruction class and the state-independent datapath selects
  always_comb begin
    is_arith_s     = 1'b0;
    is_branch_s    = 1'b0;
    is_mem_s       = 1'b0;
    is_jump_s      = 1'b0;
    is_halt_s      = 1'b0;
    br_taken_s     = 1'b0;
    jump_src_s     = 2'b11;
    reg_dst_s      = 2'b01;
    alu_op_s       = 3'b000;
    alu_src_a_s    = 1'b0;
    alu_src_b_s    = 1'b0;
    db_data_src_s  = 1'b0;
    wr_reg_d_src_s = 1'b1;
    ext_sel_s      = 1'b1;
    case (opcode)
      OP_ADD: begin
        is_arith_s = 1'b1;
        reg_dst_s  = 2'b10;
      end
      OP_SUB: begin
        is_arith_s = 1'b1;
        reg_dst_s  = 2'b10;
        alu_op_s   = 3'b001;
      end
      OP_ADDI: begin
        is_arith_s  = 1'b1;
        alu_src_b_s = 1'b1;
      end
      OP_OR: begin
        is_arith_s = 1'b1;
        reg_dst_s  = 2'b10;
        alu_op_s   = 3'b011;
      end
      OP_AND: begin
        is_arith_s = 1'b1;
        reg_dst_s  = 2'b10;
        alu_op_s   = 3'b100;
      end
      OP_ORI: begin
        is_arith_s  = 1'b1;
        alu_op_s    = 3'b011;
        alu_src_b_s = 1'b1;
        ext_sel_s   = 1'b0;
      end
      OP_SLL: begin
        is_arith_s  = 1'b1;
        reg_dst_s   = 2'b10;
        alu_op_s    = 3'b010;
        alu_src_a_s = 1'b1;
      end
      OP_SLT: begin
        is_arith_s = 1'b1;
        reg_dst_s  = 2'b10;
        alu_op_s   = 3'b110;
      end
      OP_SLTI: begin
        is_arith_s  = 1'b1;
        alu_op_s    = 3'b110;
        alu_src_b_s = 1'b1;
      end
      OP_SW: begin
        is_mem_s    = 1'b1;
        alu_src_b_s = 1'b1;
      end
      OP_LW: begin
        is_mem_s      = 1'b1;
        alu_src_b_s   = 1'b1;
        db_data_src_s = 1'b1;
      end
      OP_BEQ: begin
        is_branch_s = 1'b1;
        alu_op_s    = 3'b001;
        br_taken_s  = zero;
      end
      OP_BNE: begin
        is_branch_s = 1'b1;
        alu_op_s    = 3'b001;
        br_taken_s  = ~zero;
      end
      OP_BLTZ: begin
        is_branch_s = 1'b1;
        alu_op_s    = 3'b001;
        br_taken_s  = sign;
      end
      OP_J: begin
        is_jump_s = 1'b1;
      end
      OP_JR: begin
        is_jump_s  = 1'b1;
        jump_src_s = 2'b10;
      end
      OP_JAL: begin
        is_jump_s      = 1'b1;
        reg_dst_s      = 2'b00;
        wr_reg_d_src_s = 1'b0;
      end
      OP_HALT: begin
        is_halt_s = 1'b1;
      end
      default: begin
        is_arith_s = 1'b0;
      end
    endcase
  end

  // Next-state and per-state strobes; undecoded opcodes retire in ID as NOPs
  always_comb begin
    state_d   = state_q;
    pc_wre_s  = 1'b0;
    pc_src_s  = 2'b00;
    ir_wre_s  = 1'b0;
    reg_wre_s = 1'b0;
    mrd_s     = 1'b0;
    mwr_s     = 1'b0;
    case (state_q)
      S_IF: begin
        ir_wre_s = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        if (is_halt_s) begin
          state_d = S_ID;
        end else if (is_jump_s) begin
          state_d   = S_IF;
          pc_wre_s  = 1'b1;
          pc_src_s  = jump_src_s;
          reg_wre_s = ~wr_reg_d_src_s;
        end else if (is_branch_s) begin
          state_d = S_EXE_B;
        end else if (is_mem_s) begin
          state_d = S_EXE_L;
        end else if (is_arith_s) begin
          state_d = S_EXE_A;
        end else begin
          state_d  = S_IF;
          pc_wre_s = 1'b1;
        end
      end
      S_EXE_B: begin
        state_d  = S_IF;
        pc_wre_s = 1'b1;
        pc_src_s = br_taken_s ? 2'b01 : 2'b00;
      end
      S_EXE_L: begin
        state_d = S_MEM;
      end
      S_MEM: begin
        if (db_data_src_s) begin
          state_d = S_WB_L;
          mrd_s   = 1'b1;
        end else begin
          state_d  = S_IF;
          mwr_s    = 1'b1;
          pc_wre_s = 1'b1;
        end
      end
      S_WB_L: begin
        state_d   = S_IF;
        reg_wre_s = 1'b1;
        pc_wre_s  = 1'b1;
      end
      S_EXE_A: begin
        state_d = S_WB_A;
      end
      S_WB_A: begin
        state_d   = S_IF;
        reg_wre_s = 1'b1;
        pc_wre_s  = 1'b1;
      end
      default: begin
        state_d = S_IF;
      end
    endcase
  end

  // State register; reset wins over any transition, including halt
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= S_IF;
    end else begin
      state_q <= state_d;
    end
  end

  // Architectural write strobes are suppressed while reset is held
  assign PCWre     = RST & pc_wre_s;
  assign RegWre    = RST & reg_wre_s;
  assign mRD       = RST & mrd_s;
  assign mWR       = RST & mwr_s;
  assign PCSrc     = pc_src_s;
  assign IRWre     = ir_wre_s;
  assign ALUSrcA   = alu_src_a_s;
  assign ALUSrcB   = alu_src_b_s;
  assign DBDataSrc = db_data_src_s;
  assign WrRegDSrc = wr_reg_d_src_s;
  assign ExtSel    = ext_sel_s;
  assign RegDst    = reg_dst_s;
  assign ALUOp     = alu_op_s;
  assign state     = state_q;

endmodule

// File: tb/tb_control_unit.sv
// Randomized scoreboard bench for control_unit: each instruction is modelled
// as a list of cycles whose expected strobes are derived from its class.
module tb_control_unit;

  logic       CLK;
  logic       RST;
  logic [5:0] opcode;
  logic       zero;
  logic       sign;
  logic       PCWre, IRWre, RegWre, mRD, mWR;
  logic       ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel;
  logic [1:0] PCSrc, RegDst;
  logic [2:0] ALUOp, state;

  control_unit dut (
    .CLK(CLK), .RST(RST), .opcode(opcode), .zero(zero), .sign(sign),
    .PCWre(PCWre), .PCSrc(PCSrc), .IRWre(IRWre), .RegWre(RegWre),
    .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .DBDataSrc(DBDataSrc), .WrRegDSrc(WrRegDSrc), .ExtSel(ExtSel),
    .RegDst(RegDst), .ALUOp(ALUOp), .state(state)
  );

  localparam logic [5:0] ADD = 6'b000000, SUB = 6'b000001, ADDI = 6'b000010;
  localparam logic [5:0] OR_ = 6'b010000, AND_ = 6'b010001, ORI = 6'b010010;
  localparam logic [5:0] SLL = 6'b011000, SLT = 6'b100110, SLTI = 6'b100111;
  localparam logic [5:0] SW = 6'b110000, LW = 6'b110001, BEQ = 6'b110100;
  localparam logic [5:0] BNE = 6'b110101, BLTZ = 6'b110110, J = 6'b111000;
  localparam logic [5:0] JR = 6'b111001, JAL = 6'b111010, HALT = 6'b111111;

  typedef struct packed {
    logic [2:0] st;
    logic       pcwre, irwre, regwre, mrd, mwr;
    logic [1:0] pcsrc, regdst;
    logic [2:0] aluop;
    logic       srca, srcb, dbsrc, wrsrc, ext;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic bit is_arith(input logic [5:0] o);
    return o inside {ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTI};
  endfunction

  function automatic bit is_branch(input logic [5:0] o);
    return o inside {BEQ, BNE, BLTZ};
  endfunction

  // Cycle count of a whole instruction, IF included
  function automatic int n_steps(input logic [5:0] o);
    if (o == HALT) return 1000;
    if (is_branch(o)) return 3;
    if (o == LW) return 5;
    if (o == SW || is_arith(o)) return 4;
    return 2;
  endfunction

  // State code the machine shows on a given cycle of an instruction
  function automatic logic [2:0] state_at(input logic [5:0] o, input int step);
    logic [2:0] mem_path [5];
    logic [2:0] alu_path [4];
    mem_path = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    alu_path = '{3'd0, 3'd1, 3'd6, 3'd7};
    if (step == 0) return 3'd0;
    if (step == 1 || o == HALT) return 3'd1;
    if (is_branch(o)) return 3'd5;
    if (o == SW || o == LW) return mem_path[step];
    return alu_path[step];
  endfunction

  function automatic exp_t model(input logic [5:0] o, input int step,
                                 input logic z, input logic s, input logic rst_low);
    exp_t e;
    bit   last;
    bit   taken;
    last     = (step == n_steps(o) - 1) && (o != HALT);
    taken    = (o == BEQ && z) || (o == BNE && !z) || (o == BLTZ && s);
    e.st     = state_at(o, step);
    e.irwre  = (step == 0);
    e.pcwre  = !rst_low && last;
    e.regwre = !rst_low && ((last && (is_arith(o) || o == LW)) || (o == JAL && step == 1));
    e.mrd    = !rst_low && o == LW && step == 3;
    e.mwr    = !rst_low && o == SW && step == 3;
    if (o == J || o == JAL) e.pcsrc = 2'b11;
    else if (o == JR) e.pcsrc = 2'b10;
    else if (is_branch(o) && taken) e.pcsrc = 2'b01;
    else e.pcsrc = 2'b00;
    if (o == JAL) e.regdst = 2'b00;
    else if (o inside {ADD, SUB, OR_, AND_, SLL, SLT}) e.regdst = 2'b10;
    else e.regdst = 2'b01;
    if (o inside {SUB, BEQ, BNE, BLTZ}) e.aluop = 3'b001;
    else if (o == SLL) e.aluop = 3'b010;
    else if (o inside {OR_, ORI}) e.aluop = 3'b011;
    else if (o == AND_) e.aluop = 3'b100;
    else if (o inside {SLT, SLTI}) e.aluop = 3'b110;
    else e.aluop = 3'b000;
    e.srca  = (o == SLL);
    e.srcb  = o inside {ADDI, ORI, SLTI, SW, LW};
    e.dbsrc = (o == LW);
    e.wrsrc = (o != JAL);
    e.ext   = (o != ORI);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, req);
    end
  endtask

  // Monitor: pops the expectation for this cycle and compares away from the edge
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("state", {5'd0, state}, {5'd0, e.st});
        chk("IRWre", {7'd0, IRWre}, {7'd0, e.irwre});
        chk("PCWre", {7'd0, PCWre}, {7'd0, e.pcwre});
        chk("RegWre", {7'd0, RegWre}, {7'd0, e.regwre});
        chk("mRD", {7'd0, mRD}, {7'd0, e.mrd});
        chk("mWR", {7'd0, mWR}, {7'd0, e.mwr});
        if (e.pcwre) chk("PCSrc", {6'd0, PCSrc}, {6'd0, e.pcsrc});
        chk("RegDst", {6'd0, RegDst}, {6'd0, e.regdst});
        chk("ALUOp", {5'd0, ALUOp}, {5'd0, e.aluop});
        chk("srcs", {3'd0, ALUSrcA, ALUSrcB, DBDataSrc, WrRegDSrc, ExtSel},
            {3'd0, e.srca, e.srcb, e.dbsrc, e.wrsrc, e.ext});
      end
    end
  end

  // Runs one instruction; rst_step selects the cycle (if any) that holds RST low
  task automatic run_instr(input logic [5:0] o, input int force_z, input int rst_step);
    int  n;
    bit  rst_now;
    logic z, s;
    n = n_steps(o);
    for (int step = 0; step < n; step++) begin
      rst_now = (step == rst_step);
      z = (force_z >= 0) ? force_z[0] : 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      RST    = !rst_now;
      opcode = o;
      zero   = z;
      sign   = s;
      sb_q.push_back(model(o, step, z, s, rst_now));
      @(posedge CLK);
      #1;
      if (rst_now) break;
    end
  endtask

  initial begin
    logic [5:0] ops [18];
    logic [5:0] o;
    int         rs;
    ops = '{ADD, SUB, ADDI, OR_, AND_, ORI, SLL, SLT, SLTI,
            SW, LW, BEQ, BNE, BLTZ, J, JR, JAL, HALT};
    RST = 1'b0; opcode = 6'd0; zero = 1'b0; sign = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    run_instr(ADD, -1, -1);
    run_instr(LW, -1, -1);
    run_instr(BEQ, 1, -1);
    run_instr(BEQ, 0, -1);
    run_instr(JAL, -1, -1);
    run_instr(HALT, -1, 11);
    run_instr(SW, -1, 3);
    run_instr(BLTZ, -1, -1);
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 5) == 0) o = 6'($urandom_range(0, 63));
      else o = ops[$urandom_range(0, 17)];
      if (o == HALT) rs = $urandom_range(2, 12);
      else if ($urandom_range(0, 9) == 0) rs = $urandom_range(0, n_steps(o) - 1);
      else rs = -1;
      run_instr(o, -1, rs);
    end
    @(negedge CLK);
    #1;
    chk("scoreboard_drained", 8'(sb_q.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
